// File: rtl/usr_shift_sequencer.sv
// Feeds a universal shift register: one LOAD then WIDTH-1 SHIFTs per accepted word,
// optionally padded with NOP hold cycles, and strobes each bit the register presents.
module usr_shift_sequencer #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic                     Clk_In,
    input  logic                     Reset_In,
    input  logic                     Word_Valid_In,
    output logic                     Word_Ready_Out,
    input  logic [WIDTH-1:0]         Word_Data_In,
    input  logic                     Word_Dir_In,
    input  logic                     Fill_Bit_In,
    output logic                     USR_Enable_Out,
    output logic [1:0]               USR_Operation_Select_Out,
    output logic [WIDTH-1:0]         USR_Parallel_Data_Out,
    output logic                     USR_Serial_Left_Side_Data_Out,
    output logic                     USR_Serial_Right_Side_Data_Out,
    output logic                     Serial_Select_Out,
    output logic                     Bit_Valid_Out,
    output logic [$clog2(WIDTH)-1:0] Bit_Index_Out,
    output logic                     Busy_Out,
    output logic                     Done_Out
);

    localparam int unsigned IDX_W      = $clog2(WIDTH);
    localparam int unsigned HCNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned HOLD_LAST  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned SHIFT_LAST = WIDTH - 2;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic                after_load_q, after_load_d;
    logic                en_q;
    logic                dir_q, dir_d;
    logic                fill_q, fill_d;
    logic [1:0]          op_q, op_d;
    logic [WIDTH-1:0]    pdata_q, pdata_d;
    logic                sl_q, sl_d;
    logic                sr_q, sr_d;
    logic                bit_valid_q, bit_valid_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                done_q, done_d;
    logic                next_cmd;

    assign Word_Ready_Out = (state_q == ST_IDLE) && en_q;
    assign Busy_Out       = (state_q != ST_IDLE);

    // Next state; command outputs decode the next state so they are live during that state
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        shift_cnt_d  = shift_cnt_q;
        after_load_d = after_load_q;
        dir_d        = dir_q;
        fill_d       = fill_q;
        pdata_d      = pdata_q;
        op_d         = OP_NOP;
        sl_d         = sl_q;
        sr_d         = sr_q;
        bit_valid_d  = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
        bit_idx_d    = bit_idx_q;
        done_d       = 1'b0;
        next_cmd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Word_Valid_In && Word_Ready_Out) begin
                    state_d = ST_LOAD;
                    pdata_d = Word_Data_In;
                    dir_d   = Word_Dir_In;
                    fill_d  = Fill_Bit_In;
                end
            end
            ST_LOAD: begin
                after_load_d = 1'b1;
                bit_idx_d    = '0;
                if (HOLD_CYCLES > 0) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    next_cmd = 1'b1;
                end
            end
            ST_SHIFT: begin
                after_load_d = 1'b0;
                bit_idx_d    = shift_cnt_q + IDX_W'(1);
                if (HOLD_CYCLES > 0) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    next_cmd = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HCNT_W'(HOLD_LAST)) begin
                    next_cmd = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // After a bit period ends: first shift, next shift, or finish the word
        if (next_cmd) begin
            if (after_load_d) begin
                state_d     = ST_SHIFT;
                shift_cnt_d = '0;
            end else if (shift_cnt_q == IDX_W'(SHIFT_LAST)) begin
                state_d = ST_DONE;
            end else begin
                state_d     = ST_SHIFT;
                shift_cnt_d = shift_cnt_q + IDX_W'(1);
            end
        end

        if (state_d == ST_LOAD) begin
            op_d = OP_LOAD;
        end else if (state_d == ST_SHIFT) begin
            op_d = dir_d ? OP_SHR : OP_SHL;
            sl_d = fill_d;
            sr_d = fill_d;
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            shift_cnt_q  <= '0;
            after_load_q <= 1'b0;
            en_q         <= 1'b0;
            dir_q        <= 1'b0;
            fill_q       <= 1'b0;
            op_q         <= OP_NOP;
            pdata_q      <= '0;
            sl_q         <= 1'b0;
            sr_q         <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_idx_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            shift_cnt_q  <= shift_cnt_d;
            after_load_q <= after_load_d;
            en_q         <= 1'b1;
            dir_q        <= dir_d;
            fill_q       <= fill_d;
            op_q         <= op_d;
            pdata_q      <= pdata_d;
            sl_q         <= sl_d;
            sr_q         <= sr_d;
            bit_valid_q  <= bit_valid_d;
            bit_idx_q    <= bit_idx_d;
            done_q       <= done_d;
        end
    end

    assign USR_Enable_Out                 = en_q;
    assign USR_Operation_Select_Out       = op_q;
    assign USR_Parallel_Data_Out          = pdata_q;
    assign USR_Serial_Left_Side_Data_Out  = sl_q;
    assign USR_Serial_Right_Side_Data_Out = sr_q;
    assign Serial_Select_Out              = dir_q;
    assign Bit_Valid_Out                  = bit_valid_q;
    assign Bit_Index_Out                  = bit_idx_q;
    assign Done_Out                       = done_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Scoreboard bench: two sequencers (hold 0 and hold 2), each driving a behavioural USR,
// checked against bit streams and timings computed from word/dir/fill at acceptance.
module tb_usr_shift_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned NW = 24;

    typedef struct {
        int cyc;
        int idx;
        bit b;
        bit dir;
    } bit_exp_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] fin;
    } done_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register contents after LOAD plus W-1 shifts with the fill bit entering the vacated end
    function automatic logic [W-1:0] usr_final(input logic [W-1:0] w, input bit dir, input bit fill);
        int v;
        int ones;
        ones = fill ? ((1 << (W - 1)) - 1) : 0;
        if (!dir) v = ((int'(w) << (W - 1)) | ones) & ((1 << W) - 1);
        else      v = (int'(w) >> (W - 1)) | (ones << 1);
        return W'(v);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int unsigned H = (g == 0) ? 0 : 2;

        logic                 rst_n, valid, ready, dir, fill;
        logic [W-1:0]         data, pd;
        logic                 en, sl, sr, sel, bv, busy, done;
        logic [1:0]           op;
        logic [$clog2(W)-1:0] idx;
        logic [W-1:0]         usr_q;
        bit                   fin_req = 1'b0;
        bit                   fin     = 1'b0;
        bit_exp_t             bq[$];
        done_exp_t            dq[$];

        usr_shift_sequencer #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
            .Clk_In                         (clk),
            .Reset_In                       (rst_n),
            .Word_Valid_In                  (valid),
            .Word_Ready_Out                 (ready),
            .Word_Data_In                   (data),
            .Word_Dir_In                    (dir),
            .Fill_Bit_In                    (fill),
            .USR_Enable_Out                 (en),
            .USR_Operation_Select_Out       (op),
            .USR_Parallel_Data_Out          (pd),
            .USR_Serial_Left_Side_Data_Out  (sl),
            .USR_Serial_Right_Side_Data_Out (sr),
            .Serial_Select_Out              (sel),
            .Bit_Valid_Out                  (bv),
            .Bit_Index_Out                  (idx),
            .Busy_Out                       (busy),
            .Done_Out                       (done)
        );

        // Downstream universal shift register
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) usr_q <= '0;
            else if (en) begin
                case (op)
                    2'd1:    usr_q <= {usr_q[W-2:0], sr};
                    2'd2:    usr_q <= {sl, usr_q[W-1:1]};
                    2'd3:    usr_q <= pd;
                    default: usr_q <= usr_q;
                endcase
            end
        end

        int cyc       = 0;
        int last_done = 0;
        bit prev_rst  = 1'b0;
        bit held      = 1'b0;
        bit have_done = 1'b0;

        // Monitor: handshake pushes expectations, strobes and done pop and compare
        always @(negedge clk) begin
            bit_exp_t  e;
            done_exp_t de;
            logic      got;
            cyc++;
            if (!rst_n) begin
                n_tests++;
                if ({ready, en, op, pd, sl, sr, sel, bv, idx, busy, done} != '0) begin
                    n_fail++;
                    $display("FAIL h%0d reset_outputs got %h want 0", H,
                             {ready, en, op, pd, sl, sr, sel, bv, idx, busy, done});
                end
                bq.delete();
                dq.delete();
                held      = 1'b0;
                have_done = 1'b0;
            end else begin
                if (!prev_rst) begin
                    n_tests++;
                    if (!(ready && en)) begin
                        n_fail++;
                        $display("FAIL h%0d release ready=%0b en=%0b want 1 1", H, ready, en);
                    end
                end
                if (busy) begin
                    n_tests++;
                    if (ready) begin
                        n_fail++;
                        $display("FAIL h%0d ready_while_busy got 1 want 0 cyc %0d", H, cyc);
                    end
                end
                if (bv) begin
                    got = sel ? usr_q[0] : usr_q[W-1];
                    n_tests++;
                    if (bq.size() == 0) begin
                        n_fail++;
                        $display("FAIL h%0d unexpected_strobe idx %0d cyc %0d", H, idx, cyc);
                    end else begin
                        e = bq.pop_front();
                        if (cyc != e.cyc || int'(idx) != e.idx || got != e.b || sel != e.dir) begin
                            n_fail++;
                            $display("FAIL h%0d strobe got cyc %0d idx %0d bit %0b sel %0b want cyc %0d idx %0d bit %0b sel %0b",
                                     H, cyc, idx, got, sel, e.cyc, e.idx, e.b, e.dir);
                        end
                    end
                end
                if (done) begin
                    n_tests++;
                    if (dq.size() == 0) begin
                        n_fail++;
                        $display("FAIL h%0d unexpected_done cyc %0d", H, cyc);
                    end else begin
                        de = dq.pop_front();
                        if (cyc != de.cyc || usr_q != de.fin) begin
                            n_fail++;
                            $display("FAIL h%0d done got cyc %0d usr %h want cyc %0d usr %h",
                                     H, cyc, usr_q, de.cyc, de.fin);
                        end
                    end
                    have_done = 1'b1;
                    last_done = cyc;
                end
                if (valid && ready) begin
                    if (held && have_done) begin
                        n_tests++;
                        if (cyc != last_done + 1) begin
                            n_fail++;
                            $display("FAIL h%0d b2b_accept got cyc %0d want %0d", H, cyc, last_done + 1);
                        end
                    end
                    for (int i = 0; i < int'(W); i++) begin
                        e.cyc = cyc + 2 + i * (int'(H) + 1);
                        e.idx = i;
                        e.b   = 1'((int'(data) >> (dir ? i : int'(W) - 1 - i)) & 1);
                        e.dir = dir;
                        bq.push_back(e);
                    end
                    de.cyc = cyc + 1 + int'(W) * (int'(H) + 1);
                    de.fin = usr_final(data, dir, fill);
                    dq.push_back(de);
                    held      = 1'b1;
                    have_done = 1'b0;
                end else if (!valid) begin
                    held = 1'b0;
                end
                if (fin_req && !fin) begin
                    n_tests++;
                    if (bq.size() != 0 || dq.size() != 0) begin
                        n_fail++;
                        $display("FAIL h%0d drain pending strobes %0d dones %0d want 0 0", H, bq.size(), dq.size());
                    end
                    fin = 1'b1;
                end
            end
            prev_rst = rst_n;
        end

        // Stimulus: directed words, back-to-back pair, random words, mid-LOAD reset
        initial begin
            logic [W-1:0] wd[NW];
            bit           wdir[NW];
            bit           wfill[NW];
            bit           wb2b[NW];
            int           wait_n;
            wd[0] = 4'hB; wdir[0] = 1'b0; wfill[0] = 1'b0; wb2b[0] = 1'b0;
            wd[1] = 4'h6; wdir[1] = 1'b1; wfill[1] = 1'b1; wb2b[1] = 1'b0;
            wd[2] = 4'h9; wdir[2] = 1'b0; wfill[2] = 1'b1; wb2b[2] = 1'b0;
            wd[3] = 4'hA; wdir[3] = 1'b0; wfill[3] = 1'b0; wb2b[3] = 1'b1;
            wd[4] = 4'h5; wdir[4] = 1'b1; wfill[4] = 1'b0; wb2b[4] = 1'b0;
            for (int k = 5; k < int'(NW); k++) begin
                wd[k]    = W'($urandom);
                wdir[k]  = 1'($urandom);
                wfill[k] = 1'($urandom);
                wb2b[k]  = 1'($urandom);
            end

            rst_n = 1'b0; valid = 1'b0; data = '0; dir = 1'b0; fill = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk); #1 rst_n = 1'b1;

            for (int k = 0; k < int'(NW); k++) begin
                if (k == 12) begin
                    data = 4'h3; dir = 1'b0; fill = 1'b1; valid = 1'b1;
                    wait_n = 0;
                    @(negedge clk);
                    while (!ready && wait_n < 200) begin wait_n++; @(negedge clk); end
                    @(posedge clk); #1 rst_n = 1'b0; valid = 1'b0;
                    @(negedge clk);
                    @(negedge clk); #1 rst_n = 1'b1;
                end
                data = wd[k]; dir = wdir[k]; fill = wfill[k]; valid = 1'b1;
                wait_n = 0;
                @(negedge clk);
                while (!ready && wait_n < 200) begin wait_n++; @(negedge clk); end
                if (!ready) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL h%0d accept_timeout word %0d ready 0 want 1", H, k);
                    valid = 1'b0;
                end
                @(posedge clk); #1;
                if (!wb2b[k]) begin
                    valid  = 1'b0;
                    wait_n = 0;
                    while (busy && wait_n < 200) begin
                        dir  = 1'($urandom);
                        fill = 1'($urandom);
                        data = W'($urandom);
                        @(posedge clk); #1;
                        wait_n++;
                    end
                end
            end
            valid  = 1'b0;
            wait_n = 0;
            while (busy && wait_n < 200) begin wait_n++; @(negedge clk); end
            repeat (3) @(negedge clk);
            fin_req = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(gen_inst[0].fin && gen_inst[1].fin) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout fin %0b%0b want 11", gen_inst[1].fin, gen_inst[0].fin);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
